// File: rtl/ascon_pkg.sv
// Shared constants for the Ascon-p[12] datapath:
// round constants, rotation amounts, S-box table, sizes.
package ascon_pkg;

  localparam int STATE_W = 320;
  localparam int ROUNDS  = 12;

  localparam logic [7:0] RC [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // Index k selects word xk (x0 first).
  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  function automatic logic [63:0] ror64(
    input logic [63:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] lin64(
    input logic [63:0] x,
    input int unsigned a,
    input int unsigned b
  );
    return x ^ ror64(x, a) ^ ror64(x, b);
  endfunction

endpackage

// File: rtl/ascon_sbox5.sv
// 5-bit Ascon S-box, purely combinational.
// Ports: i_x column input (x0 = MSB), o_y substituted column.
module ascon_sbox5
  import ascon_pkg::*;
(
  input  logic [4:0] i_x,
  output logic [4:0] o_y
);

  assign o_y = SBOX[i_x];

endmodule

// File: rtl/ascon_encrypt_spa.sv
// Iterated Ascon-p[12] datapath, 4 cycles per round, driven by an
// external controller. Ports: clk, reset (async low), sel1, sel2,
// sel_cst, done strobes; in = 320-bit load; out = registered result.
module ascon_encrypt_spa
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               sel1,
  input  logic               sel2,
  input  logic               sel_cst,
  input  logic               done,
  input  logic [STATE_W-1:0] in,
  output logic [STATE_W-1:0] out
);

  logic [STATE_W-1:0] r_s;
  logic [STATE_W-1:0] r_w;
  logic [STATE_W-1:0] r_out;
  logic [3:0]         r_rnd;
  logic [1:0]         r_ph;

  logic [3:0]         w_ridx;
  logic [7:0]         w_rc;
  logic [STATE_W-1:0] w_cst;
  logic [STATE_W-1:0] w_sub;
  logic [STATE_W-1:0] w_lin;
  logic [4:0]         w_sbi [64];
  logic [4:0]         w_sbo [64];

  // Round index wraps mod 16; indices 12..15 reuse C[rnd-12].
  assign w_ridx = (r_rnd >= 4'd12) ? (r_rnd - 4'd12) : r_rnd;
  assign w_rc   = RC[w_ridx];

  // Constant lands in the low byte of x2 = state[135:128].
  assign w_cst = {r_s[319:136], r_s[135:128] ^ w_rc, r_s[127:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_col
      assign w_sbi[gi] = {r_w[256+gi], r_w[192+gi],
                          r_w[128+gi], r_w[64+gi], r_w[gi]};
      ascon_sbox5 u_sbox (
        .i_x (w_sbi[gi]),
        .o_y (w_sbo[gi])
      );
      assign {w_sub[256+gi], w_sub[192+gi], w_sub[128+gi],
              w_sub[64+gi], w_sub[gi]} = w_sbo[gi];
    end
  endgenerate

  genvar gk;
  generate
    for (gk = 0; gk < 5; gk++) begin : g_lin
      localparam int LO = 256 - 64 * gk;
      assign w_lin[LO +: 64] =
        lin64(r_w[LO +: 64], ROT_A[gk], ROT_B[gk]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s   <= '0;
      r_w   <= '0;
      r_out <= '0;
      r_rnd <= '0;
      r_ph  <= '0;
    end else if (sel1 && sel2) begin
      r_s   <= in;
      r_w   <= in;
      r_rnd <= '0;
      r_ph  <= '0;
    end else if (sel2) begin
      r_s   <= r_w;
      r_rnd <= r_rnd + 4'd1;
      if (done) r_out <= r_w;
    end else if (sel_cst) begin
      r_w  <= w_cst;
      r_ph <= 2'd1;
    end else if (r_ph == 2'd1) begin
      r_w  <= w_sub;
      r_ph <= 2'd2;
    end else if (r_ph == 2'd2) begin
      r_w  <= w_lin;
      r_ph <= 2'd3;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_ascon_encrypt_spa.sv
// Scoreboard bench for ascon_encrypt_spa: expected permutation results
// are queued at load time and checked when the done commit is seen.
module tb_ascon_encrypt_spa;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sel1 = 1'b0;
  logic         sel2 = 1'b0;
  logic         sel_cst = 1'b0;
  logic         done = 1'b0;
  logic [319:0] din = '0;
  logic [319:0] dout;

  int errors = 0;
  int checks = 0;

  logic [319:0] exp_q [$];

  always #5 clk = ~clk;

  ascon_encrypt_spa dut (
    .clk     (clk),
    .reset   (reset),
    .sel1    (sel1),
    .sel2    (sel2),
    .sel_cst (sel_cst),
    .done    (done),
    .in      (din),
    .out     (dout)
  );

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bitsliced reference round.
  function automatic logic [319:0] mround(input logic [319:0] s,
                                          input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  rc;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128];
    x3 = s[127:64];  x4 = s[63:0];
    rc = 8'(((15 - r) << 4) | r);
    x2 = x2 ^ {56'h0, rc};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
    t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ rr(x0, 19) ^ rr(x0, 28);
    x1 = x1 ^ rr(x1, 61) ^ rr(x1, 39);
    x2 = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
    x3 = x3 ^ rr(x3, 10) ^ rr(x3, 17);
    x4 = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] p12(input logic [319:0] s);
    logic [319:0] t;
    t = s;
    for (int r = 0; r < 12; r++) t = mround(t, r);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act,
                     input logic [319:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic s1, input logic s2,
                       input logic c, input logic d,
                       input logic [319:0] v);
    @(negedge clk);
    sel1 = s1; sel2 = s2; sel_cst = c; done = d; din = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0);
  endtask

  // Load v, run nr rounds; done on the 12th commit when fin is set.
  // Out must keep value hold across every non-final commit.
  task automatic run(input logic [319:0] v, input int nr,
                     input bit fin, input logic [319:0] hold);
    if (fin) exp_q.push_back(p12(v));
    drive(1, 1, 0, 0, v);
    for (int r = 0; r < nr; r++) begin
      drive(0, 0, 1, 0, '0);
      drive(0, 0, 0, 0, '0);
      drive(0, 0, 0, 0, '0);
      drive(0, 1, 0, fin && (r == 11), '0);
      if (!(fin && r == 11)) begin
        @(posedge clk); #1;
        chk($sformatf("out_hold_r%0d", r), dout, hold);
      end
    end
  endtask

  // Monitor: the final commit edge presents a new result.
  initial begin
    forever begin
      @(posedge clk);
      if (reset && sel2 && !sel1 && done) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected actual=%h required=none", dout);
        end else begin
          chk("sb_result", dout, exp_q.pop_front());
        end
      end
    end
  end

  logic [319:0] ones_v;
  logic [319:0] rv;
  logic [319:0] va, vb;

  initial begin
    ones_v = '1;
    #12;
    chk("reset_out", dout, '0);
    chk("reset_s", dut.r_s, '0);
    @(negedge clk); reset = 1'b1;

    run('0, 12, 1, '0);
    run(ones_v, 12, 1, p12('0));
    va = p12(ones_v);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 10; j++) rv[32*j +: 32] = $urandom;
      run(rv, 12, 1, va);
      va = p12(rv);
    end
    idle(1);

    // One round from zero: S must hold round-0 result.
    run('0, 1, 0, va);
    idle(1);
    chk("one_round_s", dut.r_s, mround('0, 0));
    chk("one_round_x2lo",
        {312'h0, mround('0, 0)[191:128] == dut.r_s[191:128]},
        {312'h0, 1'b1});

    // Abort mid-run at round 5.
    run(ones_v, 5, 0, va);
    drive(0, 0, 1, 0, '0);
    @(negedge clk); reset = 1'b0; #1;
    chk("abort_out", dout, '0);
    chk("abort_s", dut.r_s, '0);
    @(negedge clk); reset = 1'b1;
    sel_cst = 1'b0;
    idle(2);
    chk("after_abort_out", dout, '0);
    run('0, 12, 1, '0);

    // Back-to-back, B loaded on the edge after A's final commit.
    va = {64'h0123456789ABCDEF, 64'h0, 64'hFFFF0000FFFF0000,
          64'h8000000000000001, 64'hDEADBEEFCAFEF00D};
    vb = {5{64'h5555AAAA3333CCCC}};
    run(va, 12, 1, p12('0));
    run(vb, 12, 1, p12(va));

    idle(20);
    chk("idle_out", dout, p12(vb));
    chk("idle_s", dut.r_s, p12(vb));

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_pending actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
